// File: rtl/video_sig_gen_if.sv
// Video timing bundle between video_sig_gen (master) and its consumer (slave).
// The consumer drives the pixel-advance enable; the generator drives the
// counters and the sync/draw/frame outputs.
interface video_sig_gen_if;
    logic        en_in;
    logic [10:0] hcount_out;
    logic [9:0]  vcount_out;
    logic        hs_out;
    logic        vs_out;
    logic        ad_out;
    logic        nf_out;
    logic [5:0]  fc_out;

    modport master (
        input  en_in,
        output hcount_out, vcount_out, hs_out, vs_out, ad_out, nf_out, fc_out
    );

    modport slave (
        output en_in,
        input  hcount_out, vcount_out, hs_out, vs_out, ad_out, nf_out, fc_out
    );
endinterface

// File: rtl/video_sig_gen.sv
// Video timing source: free-running horizontal/vertical counters with sync,
// active-draw, new-frame and frame-count outputs. All outputs are registered
// and decoded from the *next* counter values, so hs/vs/ad/nf always describe
// the hcount/vcount presented in the same cycle.
// Optional feature: define VIDEO_SIG_GEN_FRAME_COUNT_EN to build the frame
// counter; otherwise fc_out is tied to zero.
module video_sig_gen #(
    parameter int ACTIVE_H_PIXELS = 1280,
    parameter int H_FRONT_PORCH   = 110,
    parameter int H_SYNC_WIDTH    = 40,
    parameter int H_BACK_PORCH    = 220,
    parameter int ACTIVE_LINES    = 720,
    parameter int V_FRONT_PORCH   = 5,
    parameter int V_SYNC_WIDTH    = 5,
    parameter int V_BACK_PORCH    = 20,
    parameter int FPS             = 60
) (
    input  logic            clk_in,
    input  logic            rst_in,
    video_sig_gen_if.master vid
);
    localparam int H_TOTAL = ACTIVE_H_PIXELS + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH;
    localparam int V_TOTAL = ACTIVE_LINES + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    // Region bounds kept one bit wider so an exclusive end of 2048/1024 is representable.
    localparam logic [11:0] H_ACT_END = 12'(ACTIVE_H_PIXELS);
    localparam logic [11:0] HS_BEGIN  = 12'(ACTIVE_H_PIXELS + H_FRONT_PORCH);
    localparam logic [11:0] HS_END    = 12'(ACTIVE_H_PIXELS + H_FRONT_PORCH + H_SYNC_WIDTH);
    localparam logic [10:0] V_ACT_END = 11'(ACTIVE_LINES);
    localparam logic [10:0] VS_BEGIN  = 11'(ACTIVE_LINES + V_FRONT_PORCH);
    localparam logic [10:0] VS_END    = 11'(ACTIVE_LINES + V_FRONT_PORCH + V_SYNC_WIDTH);

    // Half-open interval test used by the horizontal sync decode.
    function automatic logic in_span_h(input logic [11:0] val, input logic [11:0] lo,
                                       input logic [11:0] hi);
        return (val >= lo) && (val < hi);
    endfunction

    // Half-open interval test used by the vertical sync decode.
    function automatic logic in_span_v(input logic [10:0] val, input logic [10:0] lo,
                                       input logic [10:0] hi);
        return (val >= lo) && (val < hi);
    endfunction

    logic [10:0] hcount_q, hcount_d;
    logic [9:0]  vcount_q, vcount_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        ad_q, ad_d;
    logic        nf_q, nf_d;
    logic [10:0] h_next_s;
    logic [9:0]  v_next_s;
    logic        h_wrap_s;

    // Position the counters would move to on an enabled pixel clock.
    always_comb begin
        h_wrap_s = (hcount_q == H_LAST);
        if (h_wrap_s) begin
            h_next_s = 11'd0;
        end else begin
            h_next_s = hcount_q + 11'd1;
        end
        if (!h_wrap_s) begin
            v_next_s = vcount_q;
        end else if (vcount_q == V_LAST) begin
            v_next_s = 10'd0;
        end else begin
            v_next_s = vcount_q + 10'd1;
        end
    end

    // Advance and decode on enable; a stall holds everything except the nf pulse.
    always_comb begin
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        hs_d     = hs_q;
        vs_d     = vs_q;
        ad_d     = ad_q;
        nf_d     = 1'b0;
        if (vid.en_in) begin
            hcount_d = h_next_s;
            vcount_d = v_next_s;
            hs_d     = in_span_h({1'b0, h_next_s}, HS_BEGIN, HS_END);
            vs_d     = in_span_v({1'b0, v_next_s}, VS_BEGIN, VS_END);
            ad_d     = ({1'b0, h_next_s} < H_ACT_END) && ({1'b0, v_next_s} < V_ACT_END);
            nf_d     = (h_next_s == 11'd0) && (v_next_s == 10'd0);
        end else begin
            nf_d     = 1'b0;
        end
    end

    // Timing state registers; reset parks the counters on the last pixel of a frame.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            hcount_q <= H_LAST;
            vcount_q <= V_LAST;
            hs_q     <= 1'b0;
            vs_q     <= 1'b0;
            ad_q     <= 1'b0;
            nf_q     <= 1'b0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            ad_q     <= ad_d;
            nf_q     <= nf_d;
        end
    end

`ifdef VIDEO_SIG_GEN_FRAME_COUNT_EN
    localparam logic [5:0] FC_LAST = 6'(FPS - 1);

    logic [5:0] fc_q, fc_d;

    // Frame counter steps on the same edge that raises nf, wrapping at FPS.
    always_comb begin
        fc_d = fc_q;
        if (nf_d) begin
            if (fc_q == FC_LAST) begin
                fc_d = 6'd0;
            end else begin
                fc_d = fc_q + 6'd1;
            end
        end else begin
            fc_d = fc_q;
        end
    end

    // Frame counter register; reset value makes the first frame read as zero.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            fc_q <= FC_LAST;
        end else begin
            fc_q <= fc_d;
        end
    end

    assign vid.fc_out = fc_q;
`else
    assign vid.fc_out = 6'd0;
`endif

    assign vid.hcount_out = hcount_q;
    assign vid.vcount_out = vcount_q;
    assign vid.hs_out     = hs_q;
    assign vid.vs_out     = vs_q;
    assign vid.ad_out     = ad_q;
    assign vid.nf_out     = nf_q;
endmodule

// File: tb/tb_video_sig_gen.sv
// Bench for video_sig_gen: one full-size 1280x720 instance and one shrunken
// instance (17x10 pixel frame) so whole frames fit in a short run. A
// linear-pixel-index reference model pushes expected outputs each edge;
// they are popped and compared after the edge.
module tb_video_sig_gen;
    localparam int A_HA = 1280, A_HFP = 110, A_HSW = 40, A_HBP = 220;
    localparam int A_VA = 720,  A_VFP = 5,   A_VSW = 5,  A_VBP = 20;
    localparam int A_HT = A_HA + A_HFP + A_HSW + A_HBP;
    localparam int A_VT = A_VA + A_VFP + A_VSW + A_VBP;
    localparam int A_N  = A_HT * A_VT;

    localparam int B_HA = 8, B_HFP = 2, B_HSW = 3, B_HBP = 4;
    localparam int B_VA = 4, B_VFP = 1, B_VSW = 2, B_VBP = 3;
    localparam int B_HT = B_HA + B_HFP + B_HSW + B_HBP;
    localparam int B_VT = B_VA + B_VFP + B_VSW + B_VBP;
    localparam int B_N  = B_HT * B_VT;

    localparam int FPS = 60;
`ifdef VIDEO_SIG_GEN_FRAME_COUNT_EN
    localparam bit FC_ON = 1'b1;
`else
    localparam bit FC_ON = 1'b0;
`endif
    localparam int FC_RST = FC_ON ? FPS - 1 : 0;

    typedef struct {
        int h;
        int v;
        bit hs;
        bit vs;
        bit ad;
        bit nf;
        int fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    video_sig_gen_if if_a ();
    video_sig_gen_if if_b ();

    video_sig_gen dut_a (.clk_in(clk), .rst_in(rst_n), .vid(if_a));

    video_sig_gen #(
        .ACTIVE_H_PIXELS(B_HA), .H_FRONT_PORCH(B_HFP), .H_SYNC_WIDTH(B_HSW), .H_BACK_PORCH(B_HBP),
        .ACTIVE_LINES(B_VA), .V_FRONT_PORCH(B_VFP), .V_SYNC_WIDTH(B_VSW), .V_BACK_PORCH(B_VBP),
        .FPS(FPS)
    ) dut_b (.clk_in(clk), .rst_in(rst_n), .vid(if_b));

    exp_t qa[$];
    exp_t qb[$];
    int total = 0;
    int bad = 0;
    int pa, pb, fca, fcb;
    bit nfa, nfb;
    int hs_cnt, ad_cnt, vs_cnt, nf_cnt;

    // Expected outputs for linear pixel index p of a frame with the given geometry.
    function automatic exp_t derive(int p, int ht, int ha, int hfp, int hsw,
                                    int va, int vfp, int vsw, bit nf, int fc);
        exp_t e;
        e.h  = p % ht;
        e.v  = p / ht;
        e.hs = (e.h >= ha + hfp) && (e.h < ha + hfp + hsw);
        e.vs = (e.v >= va + vfp) && (e.v < va + vfp + vsw);
        e.ad = (e.h < ha) && (e.v < va);
        e.nf = nf;
        e.fc = FC_ON ? fc : 0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic cmp(input string who, input exp_t e, input logic [10:0] h, input logic [9:0] v,
                       input logic hs, input logic vs, input logic ad, input logic nf,
                       input logic [5:0] fc);
        chk({who, "_h"},  32'(h),  32'(e.h));
        chk({who, "_v"},  32'(v),  32'(e.v));
        chk({who, "_hs"}, 32'(hs), 32'(e.hs));
        chk({who, "_vs"}, 32'(vs), 32'(e.vs));
        chk({who, "_ad"}, 32'(ad), 32'(e.ad));
        chk({who, "_nf"}, 32'(nf), 32'(e.nf));
        chk({who, "_fc"}, 32'(fc), 32'(e.fc));
    endtask

    task automatic model_reset();
        pa = A_N - 1;
        pb = B_N - 1;
        fca = FPS - 1;
        fcb = FPS - 1;
        nfa = 1'b0;
        nfb = 1'b0;
    endtask

    // One clock edge with the given enables: model, push, then pop/compare.
    task automatic step(input bit ea, input bit eb);
        exp_t e;
        if_a.en_in = ea;
        if_b.en_in = eb;
        @(posedge clk);
        nfa = 1'b0;
        nfb = 1'b0;
        if (rst_n) begin
            if (ea) begin
                pa = (pa + 1) % A_N;
                if (pa == 0) begin
                    nfa = 1'b1;
                    fca = (fca + 1) % FPS;
                end
            end
            if (eb) begin
                pb = (pb + 1) % B_N;
                if (pb == 0) begin
                    nfb = 1'b1;
                    fcb = (fcb + 1) % FPS;
                end
            end
        end
        qa.push_back(derive(pa, A_HT, A_HA, A_HFP, A_HSW, A_VA, A_VFP, A_VSW, nfa, fca));
        qb.push_back(derive(pb, B_HT, B_HA, B_HFP, B_HSW, B_VA, B_VFP, B_VSW, nfb, fcb));
        #1;
        e = qa.pop_front();
        cmp("a", e, if_a.hcount_out, if_a.vcount_out, if_a.hs_out, if_a.vs_out,
            if_a.ad_out, if_a.nf_out, if_a.fc_out);
        e = qb.pop_front();
        cmp("b", e, if_b.hcount_out, if_b.vcount_out, if_b.hs_out, if_b.vs_out,
            if_b.ad_out, if_b.nf_out, if_b.fc_out);
    endtask

    task automatic step_count_a();
        step(1'b1, 1'b1);
        if (if_a.hs_out === 1'b1) hs_cnt++;
        if (if_a.ad_out === 1'b1) ad_cnt++;
    endtask

    task automatic run_b_to(input int target);
        int n;
        n = 0;
        do begin
            step(1'b1, 1'b1);
            n++;
        end while (pb != target && n < 2 * B_N);
        chk("b_reach_h", 32'(if_b.hcount_out), 32'(target % B_HT));
        chk("b_reach_v", 32'(if_b.vcount_out), 32'(target / B_HT));
    endtask

    task automatic check_reset_now();
        chk("rst_a_h",  32'(if_a.hcount_out), 32'd1649);
        chk("rst_a_v",  32'(if_a.vcount_out), 32'd749);
        chk("rst_a_hs", 32'(if_a.hs_out), 32'd0);
        chk("rst_a_vs", 32'(if_a.vs_out), 32'd0);
        chk("rst_a_ad", 32'(if_a.ad_out), 32'd0);
        chk("rst_a_nf", 32'(if_a.nf_out), 32'd0);
        chk("rst_a_fc", 32'(if_a.fc_out), 32'(FC_RST));
        chk("rst_b_h",  32'(if_b.hcount_out), 32'(B_HT - 1));
        chk("rst_b_v",  32'(if_b.vcount_out), 32'(B_VT - 1));
        chk("rst_b_fc", 32'(if_b.fc_out), 32'(FC_RST));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        if_a.en_in = 1'b0;
        if_b.en_in = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #12;
        check_reset_now();
        step(1'b1, 1'b1);               // reset held: enable must not advance
        #2 rst_n = 1'b1;
        step(1'b1, 1'b1);
        chk("first_a_h",  32'(if_a.hcount_out), 32'd0);
        chk("first_a_v",  32'(if_a.vcount_out), 32'd0);
        chk("first_a_ad", 32'(if_a.ad_out), 32'd1);
        chk("first_a_nf", 32'(if_a.nf_out), 32'd1);
        chk("first_a_fc", 32'(if_a.fc_out), 32'd0);

        // Line 0 of the full-size instance with a stall just before hsync.
        hs_cnt = 0;
        ad_cnt = (if_a.ad_out === 1'b1) ? 1 : 0;
        repeat (1389) step_count_a();
        chk("a_pre_stall_h", 32'(if_a.hcount_out), 32'd1389);
        repeat (7) begin
            step(1'b0, 1'b1);
            chk("a_stall_h",  32'(if_a.hcount_out), 32'd1389);
            chk("a_stall_hs", 32'(if_a.hs_out), 32'd0);
        end
        step_count_a();
        chk("a_resume_h",  32'(if_a.hcount_out), 32'd1390);
        chk("a_resume_hs", 32'(if_a.hs_out), 32'd1);
        repeat (259) step_count_a();
        chk("a_line_end_h", 32'(if_a.hcount_out), 32'd1649);
        chk("a_hs_cycles",  32'(hs_cnt), 32'd40);
        chk("a_ad_cycles",  32'(ad_cnt), 32'd1280);
        step(1'b1, 1'b1);
        chk("a_wrap_h", 32'(if_a.hcount_out), 32'd0);
        chk("a_wrap_v", 32'(if_a.vcount_out), 32'd1);

        // Stall the small instance right on a new-frame landing.
        run_b_to(0);
        chk("b_land_nf", 32'(if_b.nf_out), 32'd1);
        repeat (5) begin
            step(1'b1, 1'b0);
            chk("b_stall0_nf", 32'(if_b.nf_out), 32'd0);
            chk("b_stall0_h",  32'(if_b.hcount_out), 32'd0);
        end
        step(1'b1, 1'b1);
        chk("b_after0_nf", 32'(if_b.nf_out), 32'd0);
        chk("b_after0_h",  32'(if_b.hcount_out), 32'd1);

        // One whole small frame: vsync spans whole lines, one nf pulse.
        vs_cnt = 0;
        nf_cnt = 0;
        repeat (B_N) begin
            step(1'b1, 1'b1);
            if (if_b.vs_out === 1'b1) vs_cnt++;
            if (if_b.nf_out === 1'b1) nf_cnt++;
        end
        chk("b_vs_cycles", 32'(vs_cnt), 32'(B_VSW * B_HT));
        chk("b_nf_count",  32'(nf_cnt), 32'd1);

        // Stall just before hsync on the first vsync line.
        run_b_to((B_VA + B_VFP) * B_HT + B_HA + B_HFP - 1);
        repeat (7) begin
            step(1'b1, 1'b0);
            chk("b_stall_hs", 32'(if_b.hs_out), 32'd0);
            chk("b_stall_vs", 32'(if_b.vs_out), 32'd1);
        end
        step(1'b1, 1'b1);
        chk("b_resume_h",  32'(if_b.hcount_out), 32'(B_HA + B_HFP));
        chk("b_resume_hs", 32'(if_b.hs_out), 32'd1);

        // Mid-run asynchronous reset, with enable held high.
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_now();
        step(1'b1, 1'b1);
        #2 rst_n = 1'b1;
        step(1'b1, 1'b1);
        chk("rerun_a_h",  32'(if_a.hcount_out), 32'd0);
        chk("rerun_a_nf", 32'(if_a.nf_out), 32'd1);
        chk("rerun_b_nf", 32'(if_b.nf_out), 32'd1);
        chk("rerun_b_fc", 32'(if_b.fc_out), 32'd0);

        // Sixty further small frames: frame counter walks 1..59 then wraps to 0.
        for (int k = 1; k <= FPS; k++) begin
            repeat (B_N) step(1'b1, 1'b1);
            chk("b_frame_nf", 32'(if_b.nf_out), 32'd1);
            chk("b_frame_fc", 32'(if_b.fc_out), FC_ON ? 32'(k % FPS) : 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
